// File: rtl/y86_pkg.sv
// y86_pkg: shared instruction, status and FSM encodings for the SEQ Y86-64 memory/write-back stage
package y86_pkg;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [1:0] S_AOK = 2'b00;
  localparam logic [1:0] S_HLT = 2'b01;
  localparam logic [1:0] S_ADR = 2'b10;
  localparam logic [1:0] S_INS = 2'b11;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'd4;
  typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_WB, ST_STOP} state_t;
  function automatic logic is_mem(input logic [3:0] ic);
    return ic inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
  endfunction
endpackage

// File: rtl/y86_regfile.sv
// y86_regfile: architectural registers, two combinational read ports, rsp tap, two ordered write ports (port 1 wins)
module y86_regfile import y86_pkg::*; #(
  parameter int DATA_W = 64,
  parameter int NREG = 15,
  parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we1,
  input  logic [3:0]        wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              we2,
  input  logic [3:0]        wa2,
  input  logic [DATA_W-1:0] wd2,
  input  logic [3:0]        rd_idx_a,
  input  logic [3:0]        rd_idx_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] rd_rsp
);
  logic [DATA_W-1:0] regs_q [16];
  logic [DATA_W-1:0] regs_d [16];
  always_comb begin
    regs_d = regs_q;
    if (we2 && int'(wa2) < NREG) regs_d[wa2] = wd2;
    if (we1 && int'(wa1) < NREG) regs_d[wa1] = wd1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < 16; i++) regs_q[i] <= (i == int'(RSP)) ? RSP_INIT : '0;
    else
      regs_q <= regs_d;
  assign rd_data_a = int'(rd_idx_a) < NREG ? regs_q[rd_idx_a] : '0;
  assign rd_data_b = int'(rd_idx_b) < NREG ? regs_q[rd_idx_b] : '0;
  assign rd_rsp = regs_q[RSP];
endmodule

// File: rtl/y86_memwb_unit.sv
// y86_memwb_unit: SEQ Y86-64 memory, write-back and PC-update stage with register file and data memory
module y86_memwb_unit import y86_pkg::*; #(
  parameter int DATA_W = 64,
  parameter int NREG = 15,
  parameter int DMEM_DEPTH = 256,
  parameter int MEM_LAT = 1,
  parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valC,
  input  logic [DATA_W-1:0] valP,
  input  logic              cnd,
  input  logic [3:0]        rd_idx_a,
  input  logic [3:0]        rd_idx_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] rd_rsp,
  output logic              done,
  output logic [DATA_W-1:0] valM,
  output logic [DATA_W-1:0] new_pc,
  output logic [1:0]        stat
);
  localparam int AW = $clog2(DMEM_DEPTH);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] icode_q, icode_d, ra_q, ra_d, rb_q, rb_d;
  logic [DATA_W-1:0] vala_q, vala_d, vale_q, vale_d, valc_q, valc_d, valp_q, valp_d;
  logic cnd_q, cnd_d;
  logic [DATA_W-1:0] valm_q, valm_d, new_pc_q, new_pc_d;
  logic [1:0] stat_q, stat_d;
  logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];
  logic idle, acc, mem_last, to_wb, c_mem, c_legal, c_cnd, wb, mem_we, we1, we2;
  logic [3:0] c_ic, wa2;
  logic [DATA_W-1:0] c_va, c_ve, c_vc, c_vp, c_addr, rdata, mem_wd, wd2;
  // In IDLE the live inputs drive decode; afterwards the latched copy does.
  assign idle = state_q == ST_IDLE;
  assign c_ic = idle ? icode : icode_q;
  assign c_va = idle ? valA : vala_q;
  assign c_ve = idle ? valE : vale_q;
  assign c_vc = idle ? valC : valc_q;
  assign c_vp = idle ? valP : valp_q;
  assign c_cnd = idle ? cnd : cnd_q;
  assign c_mem = is_mem(c_ic);
  assign c_addr = (c_ic == I_RET || c_ic == I_POPQ) ? c_va : c_ve;
  assign c_legal = c_addr < DATA_W'(DMEM_DEPTH);
  assign rdata = dmem_q[c_addr[AW-1:0]];
  assign acc = in_valid && idle;
  assign mem_last = state_q == ST_MEM && cnt_q == 8'(MEM_LAT - 1);
  assign to_wb = (acc && !(c_mem && c_legal)) || mem_last;
  assign mem_we = mem_last && icode_q inside {I_RMMOVQ, I_CALL, I_PUSHQ};
  assign mem_wd = icode_q == I_CALL ? valp_q : vala_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    {icode_d, ra_d, rb_d, vala_d, vale_d, valc_d, valp_d, cnd_d} = {icode_q, ra_q, rb_q, vala_q, vale_q, valc_q, valp_q, cnd_q};
    valm_d = valm_q;
    new_pc_d = new_pc_q;
    stat_d = stat_q;
    if (acc) begin
      {icode_d, ra_d, rb_d, vala_d, vale_d, valc_d, valp_d, cnd_d} = {icode, rA, rB, valA, valE, valC, valP, cnd};
      stat_d = icode > I_POPQ ? S_INS : icode == I_HALT ? S_HLT : (c_mem && !c_legal) ? S_ADR : S_AOK;
      state_d = (c_mem && c_legal) ? ST_MEM : ST_WB;
      cnt_d = '0;
    end
    if (state_q == ST_MEM) begin
      cnt_d = cnt_q + 8'd1;
      if (mem_last) state_d = ST_WB;
    end
    if (state_q == ST_WB) state_d = stat_q == S_AOK ? ST_IDLE : ST_STOP;
    if (to_wb)
      new_pc_d = stat_d != S_AOK ? c_vp : c_ic == I_JXX ? (c_cnd ? c_vc : c_vp) :
                 c_ic == I_CALL ? c_vc : c_ic == I_RET ? rdata : c_vp;
    if (mem_last && icode_q inside {I_MRMOVQ, I_RET, I_POPQ}) valm_d = rdata;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      {icode_q, ra_q, rb_q, vala_q, vale_q, valc_q, valp_q, cnd_q} <= '0;
      valm_q <= '0;
      new_pc_q <= '0;
      stat_q <= S_AOK;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      {icode_q, ra_q, rb_q, vala_q, vale_q, valc_q, valp_q, cnd_q} <= {icode_d, ra_d, rb_d, vala_d, vale_d, valc_d, valp_d, cnd_d};
      valm_q <= valm_d;
      new_pc_q <= new_pc_d;
      stat_q <= stat_d;
    end
  always_ff @(posedge clk)
    if (mem_we) dmem_q[c_addr[AW-1:0]] <= mem_wd;
  // Port 1 carries popq's valM so it overrides the rsp update when rA is rsp.
  assign wb = state_q == ST_WB && stat_q == S_AOK;
  assign we1 = wb && icode_q == I_POPQ;
  assign we2 = wb && (icode_q inside {I_IRMOVQ, I_OPQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ} || (icode_q == I_RRMOVQ && cnd_q));
  assign wa2 = icode_q == I_MRMOVQ ? ra_q : icode_q inside {I_CALL, I_RET, I_PUSHQ, I_POPQ} ? RSP : rb_q;
  assign wd2 = icode_q == I_MRMOVQ ? valm_q : vale_q;
  y86_regfile #(.DATA_W(DATA_W), .NREG(NREG), .RSP_INIT(RSP_INIT)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .we1(we1), .wa1(ra_q), .wd1(valm_q),
    .we2(we2), .wa2(wa2), .wd2(wd2),
    .rd_idx_a(rd_idx_a), .rd_idx_b(rd_idx_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_rsp(rd_rsp)
  );
  assign in_ready = idle;
  assign done = state_q == ST_WB;
  assign valM = valm_q;
  assign new_pc = new_pc_q;
  assign stat = stat_q;
endmodule

// File: tb/tb_y86_memwb_unit.sv
// tb_y86_memwb_unit: directed vectors with hand-computed expectations for y86_memwb_unit (MEM_LAT=2)
module tb_y86_memwb_unit;
  logic clk, rst_n, in_valid, in_ready, cnd, done;
  logic [3:0] icode, rA, rB, rd_idx_a, rd_idx_b;
  logic [63:0] valA, valE, valC, valP, rd_data_a, rd_data_b, rd_rsp, valM, new_pc;
  logic [1:0] stat;
  int checks = 0;
  int failures = 0;
  int lat;
  y86_memwb_unit #(.DATA_W(64), .NREG(15), .DMEM_DEPTH(256), .MEM_LAT(2), .RSP_INIT(64'h1000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .rA(rA), .rB(rB), .valA(valA), .valE(valE), .valC(valC), .valP(valP), .cnd(cnd),
    .rd_idx_a(rd_idx_a), .rd_idx_b(rd_idx_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_rsp(rd_rsp),
    .done(done), .valM(valM), .new_pc(new_pc), .stat(stat)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reg(input string tag, input logic [3:0] idx, input logic [63:0] exp);
    rd_idx_a = idx;
    #1;
    chk(tag, rd_data_a, exp);
  endtask
  task automatic do_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask
  task automatic run(input logic [3:0] ic, ra, rb, input logic [63:0] va, ve, vc, vp, input logic c, output int l);
    int n = 0;
    while (!in_ready && n < 10) begin
      tick();
      n++;
    end
    chk("ready", in_ready, 1);
    {icode, rA, rB, valA, valE, valC, valP, cnd} = {ic, ra, rb, va, ve, vc, vp, c};
    in_valid = 1;
    tick();
    in_valid = 0;
    l = 1;
    while (!done && l < 12) begin
      tick();
      l++;
    end
    chk("done", done, 1);
  endtask
  initial begin
    rst_n = 0;
    in_valid = 0;
    {icode, rA, rB, valA, valE, valC, valP, cnd} = '0;
    rd_idx_a = 0;
    rd_idx_b = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    chk("rst_ready", in_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_stat", stat, 0);
    chk("rst_pc", new_pc, 0);
    chk("rst_valm", valM, 0);
    chk("rst_rsp", rd_rsp, 64'h1000);
    chk("rst_rdb_none", rd_data_b, 0);
    chk_reg("rst_r4", 4, 64'h1000);
    run(4'h3, 4'hF, 4'h3, 0, 64'h55, 0, 64'h0A, 0, lat);
    chk("irmovq_lat", lat, 1);
    chk("irmovq_pc", new_pc, 64'h0A);
    chk("irmovq_stat", stat, 0);
    chk_reg("irmovq_precommit", 3, 0);
    tick();
    chk("irmovq_done_pulse", done, 0);
    chk_reg("irmovq_r3", 3, 64'h55);
    run(4'h4, 4'hF, 4'hF, 64'hDEAD, 64'h10, 0, 64'h14, 0, lat);
    chk("rmmovq_lat", lat, 3);
    chk("rmmovq_pc", new_pc, 64'h14);
    tick();
    run(4'h5, 4'h7, 4'hF, 0, 64'h10, 0, 64'h1E, 0, lat);
    chk("mrmovq_lat", lat, 3);
    chk("mrmovq_valm", valM, 64'hDEAD);
    tick();
    chk_reg("mrmovq_r7", 7, 64'hDEAD);
    run(4'h2, 4'h1, 4'h2, 0, 64'h77, 0, 64'h20, 0, lat);
    tick();
    chk_reg("cmov_nc_r2", 2, 0);
    run(4'h2, 4'h1, 4'h2, 0, 64'h77, 0, 64'h22, 1, lat);
    tick();
    chk_reg("cmov_c_r2", 2, 64'h77);
    run(4'h6, 4'h2, 4'h1, 0, 64'h33, 0, 64'h24, 0, lat);
    tick();
    chk_reg("opq_r1", 1, 64'h33);
    run(4'h7, 4'hF, 4'hF, 0, 0, 64'h40, 64'h09, 1, lat);
    chk("jxx_taken_pc", new_pc, 64'h40);
    tick();
    run(4'h7, 4'hF, 4'hF, 0, 0, 64'h40, 64'h09, 0, lat);
    chk("jxx_nt_pc", new_pc, 64'h09);
    tick();
    run(4'hA, 4'hF, 4'hF, 64'h9, 64'hF8, 0, 64'h30, 0, lat);
    chk("push_lat", lat, 3);
    tick();
    chk("push_rsp", rd_rsp, 64'hF8);
    run(4'hB, 4'h4, 4'hF, 64'hF8, 64'h100, 0, 64'h32, 0, lat);
    chk("pop_valm", valM, 64'h9);
    tick();
    chk("pop_rsp_valm_wins", rd_rsp, 64'h9);
    run(4'h8, 4'hF, 4'hF, 0, 64'h80, 64'h200, 64'h20, 0, lat);
    chk("call_pc", new_pc, 64'h200);
    tick();
    chk("call_rsp", rd_rsp, 64'h80);
    run(4'h9, 4'hF, 4'hF, 64'h80, 64'h88, 0, 64'h21, 0, lat);
    chk("ret_pc", new_pc, 64'h20);
    tick();
    chk("ret_rsp", rd_rsp, 64'h88);
    run(4'h4, 4'hF, 4'hF, 64'h1234, 64'd44, 0, 64'h40, 0, lat);
    tick();
    run(4'h4, 4'hF, 4'hF, 64'hBAD, 64'd300, 0, 64'h50, 0, lat);
    chk("adr_lat", lat, 1);
    chk("adr_stat", stat, 2);
    chk("adr_pc", new_pc, 64'h50);
    tick();
    chk("adr_stop_ready", in_ready, 0);
    tick();
    chk("adr_stop_done", done, 0);
    chk("adr_stop_stat", stat, 2);
    do_reset();
    chk("adr_rst_stat", stat, 0);
    chk_reg("adr_rst_r7", 7, 0);
    run(4'h5, 4'h5, 4'hF, 0, 64'd44, 0, 64'h52, 0, lat);
    chk("adr_mem_unchanged", valM, 64'h1234);
    tick();
    run(4'hC, 4'hF, 4'hF, 0, 0, 0, 64'h60, 0, lat);
    chk("ins_lat", lat, 1);
    chk("ins_stat", stat, 3);
    tick();
    chk("ins_stop_ready", in_ready, 0);
    do_reset();
    run(4'h0, 4'hF, 4'hF, 0, 0, 0, 64'h77, 0, lat);
    chk("hlt_stat", stat, 1);
    chk("hlt_pc", new_pc, 64'h77);
    tick();
    chk("hlt_stop_ready", in_ready, 0);
    do_reset();
    run(4'h3, 4'hF, 4'h6, 0, 64'h66, 0, 64'h80, 0, lat);
    tick();
    run(4'h4, 4'hF, 4'hF, 64'h1111, 64'h20, 0, 64'h82, 0, lat);
    tick();
    {icode, valA, valE} = {4'h4, 64'hAAAA, 64'h20};
    in_valid = 1;
    tick();
    in_valid = 0;
    chk("midmem_busy", in_ready, 0);
    rst_n = 0;
    #2;
    chk("midmem_rst_ready", in_ready, 1);
    chk("midmem_rst_rsp", rd_rsp, 64'h1000);
    chk_reg("midmem_rst_r6", 6, 0);
    rst_n = 1;
    tick();
    run(4'h5, 4'h5, 4'hF, 0, 64'h20, 0, 64'h84, 0, lat);
    chk("midmem_no_write", valM, 64'h1111);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/y86_memwb_unit.md
Name: y86_memwb_unit

Overview:
Parametrised memory + write-back + PC-update stage for the SEQ Y86-64 core. Owns the architectural register file and the word-addressed data memory, which until now were modelled ad hoc in the processor bench. Accepts one decoded/executed instruction at a time over a valid/ready handshake and models a configurable memory latency. Commits register writes, produces valM, next PC and a sticky processor status.

Parameters:
DATA_W, 64, datapath / register width
NREG, 15, architectural registers (index 0xF = none)
DMEM_DEPTH, 256, data memory words; address = valE or valA used directly as word index
MEM_LAT, 1, cycles spent in MEM state for memory ops (>=1)
RSP_INIT, 0, reset value of register 4 (%rsp)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  instruction fields valid
in_ready  out  1  unit can accept
icode  in  4  instruction code
rA  in  4  register A index
rB  in  4  register B index
valA  in  DATA_W  decode operand A
valE  in  DATA_W  execute result
valC  in  DATA_W  constant word
valP  in  DATA_W  fall-through PC
cnd  in  1  condition result
rd_idx_a  in  4  combinational read port A index
rd_idx_b  in  4  combinational read port B index
rd_data_a  out  DATA_W  reg[rd_idx_a], 0 if index >= NREG
rd_data_b  out  DATA_W  reg[rd_idx_b], 0 if index >= NREG
rd_rsp  out  DATA_W  reg[4]
done  out  1  one-cycle pulse: instruction retired
valM  out  DATA_W  memory read value (held until next retire)
new_pc  out  DATA_W  next PC (valid with done, held)
stat  out  2  00 AOK, 01 HLT, 10 ADR, 11 INS

Behaviour:
- Reset (async, rst_n=0): state IDLE; regs 0 except reg[4]=RSP_INIT; done=0, valM=0, new_pc=0, stat=AOK. Data memory not reset. Reset mid-operation aborts the instruction; no write lands.
- FSM: IDLE, MEM, WB, STOP.
- in_ready = (state==IDLE). Accept on rising edge with in_valid && in_ready; all inputs latched at accept.
- IDLE->MEM for rmmovq(4), mrmovq(5), call(8), ret(9), pushq(A), popq(B) with legal address; else IDLE->WB.
- MEM: counter runs MEM_LAT cycles, then ->WB. Writes mem at entry into WB; read data captured into valM at the same point.
- WB: done=1 for exactly this cycle; register writes commit at the edge leaving WB; ->IDLE, or ->STOP if stat!=AOK.
- Latency accept->done: 1 cycle non-memory, 1+MEM_LAT memory.
- Addresses: write/read address = valE for rmmovq, mrmovq, call, pushq; valA for ret, popq. Address >= DMEM_DEPTH -> stat=ADR, skip MEM, no memory or register writes, new_pc=valP.
- Per icode (writes at WB exit):
  - 0 halt: HLT, new_pc=valP.
  - 1 nop: no writes.
  - 2 cmovXX: reg[rB]=valE only if cnd.
  - 3 irmovq: reg[rB]=valE.
  - 4 rmmovq: mem=valA.
  - 5 mrmovq: reg[rA]=valM.
  - 6 OPq: reg[rB]=valE.
  - 7 jXX: new_pc = cnd ? valC : valP.
  - 8 call: mem=valP, reg[4]=valE, new_pc=valC.
  - 9 ret: reg[4]=valE, new_pc=valM.
  - A pushq: mem=valA, reg[4]=valE.
  - B popq: reg[4]=valE, then reg[rA]=valM.
  - icode > 0xB: INS.
- new_pc=valP unless stated.
- Write port priority: popq with rA==4 leaves reg[4]=valM. Writes to index 0xF or >= NREG are dropped.
- Read ports combinational, no bypass: during WB they show pre-commit values.
- STOP: sticky; in_ready=0, done=0, outputs hold; exits only via reset.

Decomposition:
- Package y86_pkg: icode constants (I_HALT..I_POPQ), stat encodings, RNONE=4'hF, RSP=4'd4.
- One sub-module, y86_regfile: NREG x DATA_W, two combinational read ports plus rsp tap, two ordered write ports (port 1 wins), async reset.
- Memory array inline.

Test Plan:
- Reset, irmovq rB=3 valE=0x55: done 1 cycle after accept; rd_data_a(idx 3)=0x55; new_pc=valP.
- MEM_LAT=2, rmmovq valE=0x10 valA=0xDEAD, then mrmovq rA=7 valE=0x10: done 3 cycles after accept; valM=0xDEAD; reg7=0xDEAD.
- Cmov flows: cmovXX cnd=0 rB=2 leaves reg2; jXX cnd=1 valC=0x40 gives new_pc=0x40.
- Stack: pushq valA=9 valE=0xF8, then popq rA=4 valA=0xF8 valE=0x100: reg4=9 (valM wins).
- call valP=0x20 valE=0x80 valC=0x200 then ret valA=0x80: new_pc=0x200 then 0x20.
- Faults: rmmovq valE=300 (DEPTH 256) -> stat=ADR, memory unchanged, in_ready stays 0. icode 0xC -> INS. rst_n low during MEM -> all regs reset, no memory write.
